// File: rtl/data_memo_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the 32-word data memory.
// Define DATA_MEMO_ARB_RANGE_CHECK_EN to flag and suppress accesses at addresses >= DEPTH.
module data_memo_arbiter #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_address,
  output logic [31:0] mem_input_data,
  output logic        mem_enable_read,
  output logic        mem_enable_write,
  input  logic [31:0] mem_read_data
);

`ifdef DATA_MEMO_ARB_RANGE_CHECK_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q;
  logic          owner_q;
  logic          we_q;
  logic          hi_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata0_q, rdata1_q;
  logic          err0_q, err1_q;
  logic          oor;
  logic          in_idle, in_access, in_resp;

  assign in_idle   = (state_q == IDLE)   && !rst;
  assign in_access = (state_q == ACCESS) && !rst;
  assign in_resp   = (state_q == RESP)   && !rst;

  // last_q = 1 means port 1 owned the previous grant, so port 0 wins a tie.
  assign gnt0 = in_idle && req0 && (!req1 ||  last_q);
  assign gnt1 = in_idle && req1 && (!req0 || !last_q);

  assign oor = RangeEn && hi_q;

  assign mem_address      = in_access ? {{(32-AW){1'b0}}, addr_q} : 32'd0;
  assign mem_input_data   = in_access ? wdata_q : 32'd0;
  assign mem_enable_write = in_access &&  we_q && !oor;
  assign mem_enable_read  = in_access && !we_q && !oor;

  assign ack0   = in_resp && !owner_q;
  assign ack1   = in_resp &&  owner_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      hi_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt0 || gnt1) begin
        last_q  <= gnt1;
        owner_q <= gnt1;
        we_q    <= gnt1 ? we1 : we0;
        addr_q  <= gnt1 ? addr1[AW-1:0] : addr0[AW-1:0];
        hi_q    <= gnt1 ? (addr1 >= 32'(DEPTH)) : (addr0 >= 32'(DEPTH));
        wdata_q <= gnt1 ? wdata1 : wdata0;
      end
      // Read data and error status settle at the closing edge of ACCESS, ready for RESP.
      if (state_q == ACCESS) begin
        if (!owner_q) begin
          err0_q <= oor;
          if (!we_q) rdata0_q <= oor ? 32'd0 : mem_read_data;
        end else begin
          err1_q <= oor;
          if (!we_q) rdata1_q <= oor ? 32'd0 : mem_read_data;
        end
      end
    end
  end

endmodule

// File: doc/data_memo_arbiter.md
# data_memo_arbiter

- Two-requester arbiter and sequencer for the 32-entry data memory (`DataMemoModule`).
- Accepts independent load/store requests from port 0 (CPU load/store unit) and port 1 (debug/loader port). It serialises them with round-robin fairness and drives the memory's address, data and enable strobes.
- Returns read data and a completion pulse to the requester that owned the access.
- Sits between the requesters and the single memory instance; it is the only driver of the memory's inputs.

## Interface

Parameters:
- `DEPTH`, 32: number of memory words; address-range limit.
- `AW`, 5: index bits used to address memory, clog2(`DEPTH`).

Ports. `bus_type` is the 32-bit bus type from `types`. One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  access request, held until granted.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid while `reqN`.
- `addr0` / `addr1`  in  `bus_type`  word address.
- `wdata0` / `wdata1`  in  `bus_type`  write data.
- `gnt0` / `gnt1`  out  1  request accepted this cycle (Mealy).
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  `bus_type`  read result, valid from `ackN` of a read.
- `err0` / `err1`  out  1  access error, valid with `ackN`.
- `mem_address`  out  `bus_type`  to memory `address`.
- `mem_input_data`  out  `bus_type`  to memory `input_data`.
- `mem_enable_read` / `mem_enable_write`  out  1  memory strobes.
- `mem_read_data`  in  `bus_type`  from memory `read_data`; combinational.

## Operation

FSM states:
- IDLE -> ACCESS when any `reqN` is high.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.

Arbitration (IDLE only):
- Exactly one `gntN` is high when at least one `reqN` is high.
- Single requester: it wins.
- Both requesting: the port that was not granted last wins.
- Pointer `last` (1 bit) updates on every grant; reset value 1, so port 0 wins the first tie.

Capture on grant: `we`, `addr`, `wdata` and the owner id are latched at the IDLE edge. Requester inputs are don't-care after `gnt`.

ACCESS (exactly one cycle):
- `mem_address` = latched address.
- `mem_input_data` = latched wdata.
- `mem_enable_write` = `we`; `mem_enable_read` = !`we`.
- A write commits at the closing edge.
- A read captures `mem_read_data` into the owner's `rdataN` at the closing edge.

RESP: owner's `ackN` = 1 for one cycle; `errN` valid.

Outside ACCESS:
- All `mem_*` outputs are 0, so the memory is never strobed spuriously.

Read-data and status holding:
- `rdataN` holds its value until the next read completion on that port; writes leave it unchanged.
- `errN` is updated only at completion on that port.

Reset:
- `rst` asserted forces IDLE immediately; all outputs go to 0, `last` = 1, `rdataN` = 0.
- Reset during ACCESS drops `mem_enable_write` asynchronously, so the in-flight write does not commit.
- An aborted transaction never acks; requesters must re-request after reset.
- Memory contents are not reset.

## Timing

- Request sampled high in IDLE at cycle T: `gnt` at T, memory strobes at T+1, `ack` and `rdata` at T+2, next grant possible at T+3.
- Sustained throughput: one access per 3 cycles.
- Both ports requesting continuously alternate 0,1,0,1…
- `gntN` is combinational from `reqN`, state and `last`; no combinational path from `mem_read_data` to any output.
- A request raised during ACCESS or RESP waits; it is first considered at the next IDLE cycle.
- Deassertion before `gnt` withdraws the request with no side effect.

## Configuration

- `DATA_MEMO_ARB_RANGE_CHECK_EN` defined:
  - Any latched address ≥ `DEPTH` (bits [31:`AW`] nonzero) suppresses both memory strobes in ACCESS.
  - The transaction still completes: `ackN` = 1, `errN` = 1.
  - A read returns `rdataN` = 0.
  - In-range accesses have `errN` = 0.
- Not defined:
  - `mem_address` = {0, addr[`AW`-1:0]}; the address wraps modulo `DEPTH`.
  - `err0` and `err1` are tied to 0.

## Test plan

- Write/read: port 0 writes 0xDEADBEEF to addr 7, then reads addr 7 -> `ack0` at T+2 each; `rdata0` = 0xDEADBEEF; `err0` = 0.
- Tie: `req0` = `req1` = 1 from reset, held -> grants 0,1,0,1 every 3 cycles; one `ackN` per grant; no cycle with both `gnt` high.
- Port isolation: port 1 reads addr 3 (0x11) while `rdata0` holds 0x22 -> `rdata1` = 0x11; `rdata0` stays 0x22.
- Reset in flight: port 1 writes 0x55 to addr 4 (previously 0x99); assert `rst` in ACCESS before the edge -> no `ack1`, outputs 0; later read of addr 4 returns 0x99.
- Out-of-range, with macro: port 0 reads addr 40 -> strobes stay 0, `ack0` = 1, `err0` = 1, `rdata0` = 0.
- Out-of-range, without macro: write to addr 40 lands at addr 8; `err0` = 0.
